// File: rtl/nand_chain_tester.sv
// Sweeps all 16 input vectors through an external four-input NAND chain and
// checks its e/f/g outputs against the expected logic values.
module nand_chain_tester #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       e_in,
  input  logic       f_in,
  input  logic       g_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail,
  output logic       fail_valid
);

  // state | meaning
  // IDLE  | waiting for start; results from the last sweep held
  // HOLD  | vector driven, waiting SETTLE cycles for the chain to settle
  // CHECK | compare chain outputs with expected values, advance vector
  // FIN   | one-cycle done pulse, pass latched
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("nand_chain_tester: SETTLE must be in 1..15");
  end

  state_t     state_q;
  logic [3:0] idx_q;
  logic [3:0] hold_cnt_q;
  logic [4:0] err_q;
  logic [3:0] first_fail_q;
  logic       fail_valid_q;
  logic       pass_q;
  logic       busy_q;
  logic       done_q;

  logic       exp_e;
  logic       exp_f;
  logic       exp_g;
  logic       mismatch_d;
  logic [4:0] err_d;

  always_comb begin
    exp_e      = ~(idx_q[3] & idx_q[2]);
    exp_f      = ~(idx_q[1] & exp_e);
    exp_g      = ~(idx_q[0] & exp_f);
    mismatch_d = (e_in != exp_e) | (f_in != exp_f) | (g_in != exp_g);
    err_d      = err_q;
    if (mismatch_d && err_q != 5'd16) begin
      err_d = err_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      hold_cnt_q   <= 4'd0;
      err_q        <= 5'd0;
      first_fail_q <= 4'd0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= HOLD;
            idx_q        <= 4'd0;
            hold_cnt_q   <= SETTLE_L;
            err_q        <= 5'd0;
            first_fail_q <= 4'd0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt_q == 4'd1) begin
            state_q <= CHECK;
          end else begin
            hold_cnt_q <= hold_cnt_q - 4'd1;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch_d && !fail_valid_q) begin
            first_fail_q <= idx_q;
            fail_valid_q <= 1'b1;
          end
          // idx stays at 15 after the last vector so a..d hold the final stimulus
          if (idx_q == 4'd15) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 5'd0);
          end else begin
            state_q    <= HOLD;
            idx_q      <= idx_q + 4'd1;
            hold_cnt_q <= SETTLE_L;
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a          = idx_q[3];
  assign b          = idx_q[2];
  assign c          = idx_q[1];
  assign d          = idx_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = first_fail_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_nand_chain_tester.sv
// Bench for nand_chain_tester: two instances (SETTLE=2 and SETTLE=1) driving
// a modelled NAND chain with selectable fault modes.
module tb_nand_chain_tester;

  typedef struct {
    int sel;
    int mode;
    int exp_err;
    int exp_first;
    int exp_fv;
    int exp_pass;
    int repulse;
  } vec_t;

  typedef struct {
    int sel;
    int err;
    int first;
    int fv;
    int pass;
    int len;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [2];
  logic       e_w [2];
  logic       f_w [2];
  logic       g_w [2];
  logic       a_w [2];
  logic       b_w [2];
  logic       c_w [2];
  logic       d_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       pass_w [2];
  logic [4:0] err_w [2];
  logic [3:0] ff_w [2];
  logic       fv_w [2];
  int         mode_v [2];
  int         blen [2];

  sb_t sbq[$];
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;

  // Chain model: 0 good, 1 g stuck 0, 2 e stuck 1, 3 all inverted, 4 f stuck 0, 5 g stuck 1
  function automatic logic [2:0] chain(input int mode, input logic a, b, c, d);
    logic e, f, g;
    e = ~(a & b);
    f = ~(c & e);
    g = ~(d & f);
    case (mode)
      1: g = 1'b0;
      2: e = 1'b1;
      3: begin e = ~e; f = ~f; g = ~g; end
      4: f = 1'b0;
      5: g = 1'b1;
      default: ;
    endcase
    return {e, f, g};
  endfunction

  assign {e_w[0], f_w[0], g_w[0]} = chain(mode_v[0], a_w[0], b_w[0], c_w[0], d_w[0]);
  assign {e_w[1], f_w[1], g_w[1]} = chain(mode_v[1], a_w[1], b_w[1], c_w[1], d_w[1]);

  nand_chain_tester #(.SETTLE(2)) dut (
    .clk(clk), .reset(rst), .start(start_v[0]),
    .e_in(e_w[0]), .f_in(f_w[0]), .g_in(g_w[0]),
    .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .err_count(err_w[0]), .first_fail(ff_w[0]), .fail_valid(fv_w[0])
  );

  nand_chain_tester #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(rst), .start(start_v[1]),
    .e_in(e_w[1]), .f_in(f_w[1]), .g_in(g_w[1]),
    .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .err_count(err_w[1]), .first_fail(ff_w[1]), .fail_valid(fv_w[1])
  );

  task automatic chk(input string name, input int sel, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, sel, act, exp);
    end
  endtask

  function automatic int abcd(input int k);
    return int'({a_w[k], b_w[k], c_w[k], d_w[k]});
  endfunction

  task automatic chk_zero(input string tag, input int k);
    chk({tag, "_abcd"}, k, abcd(k), 0);
    chk({tag, "_busy"}, k, int'(busy_w[k]), 0);
    chk({tag, "_done"}, k, int'(done_w[k]), 0);
    chk({tag, "_pass"}, k, int'(pass_w[k]), 0);
    chk({tag, "_err"}, k, int'(err_w[k]), 0);
    chk({tag, "_first"}, k, int'(ff_w[k]), 0);
    chk({tag, "_fv"}, k, int'(fv_w[k]), 0);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pushed sweep
  task automatic check_done(input int k);
    sb_t s;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_done dut%0d: got done, expected none", k);
    end else begin
      s = sbq.pop_front();
      chk("done_sel", k, k, s.sel);
      chk("done_err", k, int'(err_w[k]), s.err);
      chk("done_first", k, int'(ff_w[k]), s.first);
      chk("done_fv", k, int'(fv_w[k]), s.fv);
      chk("done_pass", k, int'(pass_w[k]), s.pass);
      chk("sweep_len", k, blen[k], s.len);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        blen[k] = 0;
      end else begin
        if (busy_w[k]) blen[k] = blen[k] + 1;
        if (done_w[k]) begin
          check_done(k);
          blen[k] = 0;
        end
      end
    end
  end

  task automatic pulse_start(input int sel);
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  task automatic run_sweep(input vec_t v);
    sb_t s;
    bit  got;
    mode_v[v.sel] = v.mode;
    s.sel   = v.sel;
    s.err   = v.exp_err;
    s.first = v.exp_first;
    s.fv    = v.exp_fv;
    s.pass  = v.exp_pass;
    s.len   = (v.sel == 1) ? 32 : 48;
    sbq.push_back(s);
    pulse_start(v.sel);
    chk("start_busy", v.sel, int'(busy_w[v.sel]), 1);
    chk("start_err", v.sel, int'(err_w[v.sel]), 0);
    chk("start_fv", v.sel, int'(fv_w[v.sel]), 0);
    chk("start_first", v.sel, int'(ff_w[v.sel]), 0);
    chk("start_pass", v.sel, int'(pass_w[v.sel]), 0);
    chk("start_abcd", v.sel, abcd(v.sel), 0);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      start_v[v.sel] = (v.repulse != 0) && (i == 2 || i == 19);
      @(negedge clk);
      if (done_w[v.sel]) got = 1'b1;
    end
    start_v[v.sel] = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout dut%0d: got no done, expected done within 400 cycles", v.sel);
      if (sbq.size() > 0) void'(sbq.pop_back());
    end else begin
      @(negedge clk);
      chk("done_width", v.sel, int'(done_w[v.sel]), 0);
      chk("idle_busy", v.sel, int'(busy_w[v.sel]), 0);
      repeat (4) @(negedge clk);
      chk("idle_err", v.sel, int'(err_w[v.sel]), v.exp_err);
      chk("idle_first", v.sel, int'(ff_w[v.sel]), v.exp_first);
      chk("idle_fv", v.sel, int'(fv_w[v.sel]), v.exp_fv);
      chk("idle_pass", v.sel, int'(pass_w[v.sel]), v.exp_pass);
      chk("idle_abcd", v.sel, abcd(v.sel), 15);
    end
  endtask

  vec_t vecs [9];

  initial begin
    bit found;
    //        sel mode err first fv pass repulse
    vecs[0] = '{0, 0,  0,  0,  0, 1, 0};
    vecs[1] = '{0, 1, 11,  0,  1, 0, 1};
    vecs[2] = '{0, 0,  0,  0,  0, 1, 0};
    vecs[3] = '{0, 2,  4, 12,  1, 0, 0};
    vecs[4] = '{0, 3, 16,  0,  1, 0, 0};
    vecs[5] = '{0, 4, 10,  0,  1, 0, 0};
    vecs[6] = '{0, 5,  5,  1,  1, 0, 0};
    vecs[7] = '{1, 0,  0,  0,  0, 1, 0};
    vecs[8] = '{1, 1, 11,  0,  1, 0, 0};

    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    mode_v[0]  = 0;
    mode_v[1]  = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset", 0);
    chk_zero("reset", 1);
    rst = 1'b0;

    foreach (vecs[i]) run_sweep(vecs[i]);

    // Reset in the first HOLD cycle of vector 5 aborts the sweep
    mode_v[0] = 0;
    pulse_start(0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (abcd(0) == 5) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_idx5", 0, int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midreset", 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", 0, int'(busy_w[0]), 0);
    run_sweep(vecs[0]);

    repeat (3) @(negedge clk);
    chk("sb_empty", 0, sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
